frame_timing_gen: RTL and testbench
===================================

# frame_timing_gen

Parametrised frame-timing generator for the CPU frame pipeline: counts prescaled ticks over a programmable frame period and raises a held frame request at every frame boundary. Frame consumers retire each request with an acknowledge handshake. Missed frames are counted. Up to NUM_CH compare channels emit in-frame event pulses (for example, line or vblank points). The whole block runs in one clock domain; the external prescaler supplies a single-cycle tick enable.

## Interface
- CNT_W, 19: frame counter width.
- DEFAULT_PERIOD, 450000: frame period in ticks after reset; must be ≥2 and ≤2^CNT_W.
- NUM_CH, 2: number of compare channels; must be ≥1.
- FN_W, 16: frame number width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- en  in  1  count enable; when low, counter and frame logic hold.
- tick_en  in  1  prescaler strobe; the counter advances only on cycles with en && tick_en ("advance").
- period_wr  in  1  one-cycle write strobe for period_in.
- period_in  in  CNT_W+1  new period in ticks.
- frame_ack  in  1  consumer retires the pending frame request.
- cmp_val  in  NUM_CH*CNT_W  compare points; channel i uses bits [i*CNT_W +: CNT_W].
- frame_req  out  1  frame pending; held until acknowledged.
- cmp_pulse  out  NUM_CH  one-cycle pulse per compare match.
- count  out  CNT_W  current tick count.
- frame_num  out  FN_W  frame boundary count, wrapping.
- overrun  out  1  sticky missed-frame flag.
- overrun_cnt  out  8  missed frames, saturating at 255.
- clr_overrun  in  1  clears overrun and overrun_cnt.

## Operation
- count runs from 0 to period−1. On an advance at period−1, count wraps to 0. This is the frame boundary.
- Period write:
  - period_wr latches period_in into a pending register; values below 2 are clamped to 2.
  - A pending period is applied only at a frame boundary: the active period changes on the same edge that count wraps, and governs the new frame.
  - A later write before the boundary overwrites the pending value.
- Frame request:
  - At a boundary, frame_req is set on the same edge.
  - frame_ack sampled while frame_req=1 clears frame_req on the next edge.
  - frame_ack while frame_req=0 is ignored.
- Boundary with frame_ack=1 in the same cycle: frame_req stays 1, and this is not an overrun.
- Boundary with frame_req=1 and frame_ack=0:
  - frame_req stays 1.
  - overrun is set.
  - overrun_cnt increments, saturating at 255.
- clr_overrun coinciding with an overrun event: the event wins, giving overrun=1 and overrun_cnt=1.
- frame_num increments on every boundary, including overrun boundaries, and wraps modulo 2^FN_W.
- Compare channels:
  - cmp_pulse[i]=1 for exactly one cycle when an advance loads count with cmp_val[i].
  - A cmp_val of period or above never fires.
  - cmp_val=0 fires at the boundary.
- Deasserting en mid-frame freezes count, pending period and requests. frame_ack is still honoured while en is low.

## Timing
- Reset values: count=0, active period=DEFAULT_PERIOD, no pending period, frame_req=1 (first frame due immediately), cmp_pulse=0, frame_num=0, overrun=0, overrun_cnt=0.
- Reset mid-frame aborts the frame and any pending period write.
- All outputs are registered. Boundary to frame_req, frame_num, overrun and cmp_pulse: 0 cycles, since they update on the same edge as count.
- frame_ack to frame_req low: 1 edge.
- With tick_en held high and period P, boundaries are exactly P clk cycles apart.

## Structure
- Package frame_timing_pkg:
  - default constants: CNT_W 19, DEFAULT_PERIOD 450000.
  - OVR_W=8.
  - typedef count_t.
  - function clamp_period.
- Sub-module frame_cmp_channel: one compare register plus pulse flop, instantiated NUM_CH times via generate.
- The counter, period shadow, handshake and overrun logic stay in the top level.

## Test plan
- Reset with period_wr=0, en=1, tick_en=1, P=DEFAULT_PERIOD:
  - frame_req=1 after reset;
  - ack it;
  - next frame_req rises when count wraps 449999→0, frame_num=1.
- Write period_in=10 mid-frame:
  - the current frame keeps its old length;
  - the following frames are 10 ticks long.
- Write period_in=0: the period is clamped to 2, and boundaries occur every 2 ticks.
- Withhold frame_ack across 3 boundaries:
  - overrun=1, overrun_cnt=3;
  - clr_overrun gives 0/0.
- Run 300 boundaries unacked: overrun_cnt saturates at 255.
- With P=10, cmp_val0=3, cmp_val1=12, tick_en every 4th cycle:
  - cmp_pulse[0] is one-cycle high each frame at count=3;
  - cmp_pulse[1] never pulses;
  - the counter holds on non-tick cycles.

Source files
------------

// File: rtl/frame_timing_pkg.sv
// frame_timing_pkg: shared defaults, types and period clamp helper for the frame timing generator
// Contents: DEF_CNT_W / DEF_PERIOD defaults, OVR_W overrun counter width, count_t, clamp_period()
package frame_timing_pkg;
   localparam int DEF_CNT_W = 19;
   localparam int DEF_PERIOD = 450000;
   localparam int OVR_W = 8;
   typedef logic [DEF_CNT_W-1:0] count_t;
   function automatic logic [31:0] clamp_period(input logic [31:0] p);
      return (p < 32'd2) ? 32'd2 : p;
   endfunction
endpackage

// File: rtl/frame_cmp_channel.sv
// frame_cmp_channel: one compare point, pulses for one cycle when an advance loads count with cmp_val
// Ports: clk, reset_n (async, active-low), advance, next_count, cmp_val in; cmp_pulse out (registered)
module frame_cmp_channel
   import frame_timing_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             advance,
   input  logic [CNT_W-1:0] next_count,
   input  logic [CNT_W-1:0] cmp_val,
   output logic             cmp_pulse
);
   // count never reaches the active period, so values at or above it can never match
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cmp_pulse <= 1'b0;
      else cmp_pulse <= advance && (next_count == cmp_val);
endmodule

// File: rtl/frame_timing_gen.sv
// frame_timing_gen: prescaled frame counter with shadowed period, held frame request, overrun tracking and compare pulses
// Ports in: clk, reset_n (async, active-low), en, tick_en, period_wr, period_in, frame_ack, clr_overrun, cmp_val
// Ports out: frame_req, cmp_pulse, count, frame_num, overrun, overrun_cnt (all registered)
module frame_timing_gen
   import frame_timing_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int DEFAULT_PERIOD = DEF_PERIOD,
   parameter int NUM_CH = 2,
   parameter int FN_W = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    en,
   input  logic                    tick_en,
   input  logic                    period_wr,
   input  logic [CNT_W:0]          period_in,
   input  logic                    frame_ack,
   input  logic [NUM_CH*CNT_W-1:0] cmp_val,
   input  logic                    clr_overrun,
   output logic                    frame_req,
   output logic [NUM_CH-1:0]       cmp_pulse,
   output logic [CNT_W-1:0]        count,
   output logic [FN_W-1:0]         frame_num,
   output logic                    overrun,
   output logic [OVR_W-1:0]        overrun_cnt
);
   logic             advance, wrap, ovr_evt, pend_v;
   logic [CNT_W-1:0] next_count;
   logic [CNT_W:0]   period, pend;
   assign advance = en && tick_en;
   assign wrap = advance && ({1'b0, count} == period - 1'b1);
   assign next_count = wrap ? '0 : count + 1'b1;
   assign ovr_evt = wrap && frame_req && !frame_ack;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         period <= (CNT_W+1)'(DEFAULT_PERIOD);
         pend <= '0;
         pend_v <= 1'b0;
         frame_req <= 1'b1;
         frame_num <= '0;
         overrun <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         if (advance) count <= next_count;
         if (wrap) frame_num <= frame_num + 1'b1;
         if (wrap && pend_v) period <= pend;
         // a write on the boundary cycle becomes the next pending value, not the one just applied
         if (en && period_wr) begin
            pend <= (CNT_W+1)'(clamp_period(32'(period_in)));
            pend_v <= 1'b1;
         end else if (wrap) pend_v <= 1'b0;
         if (wrap) frame_req <= 1'b1;
         else if (frame_ack) frame_req <= 1'b0;
         // a missed frame outranks a simultaneous clear
         if (ovr_evt) begin
            overrun <= 1'b1;
            overrun_cnt <= clr_overrun ? OVR_W'(1) : (&overrun_cnt ? overrun_cnt : overrun_cnt + 1'b1);
         end else if (clr_overrun) begin
            overrun <= 1'b0;
            overrun_cnt <= '0;
         end
      end
   end
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      frame_cmp_channel #(.CNT_W(CNT_W)) u_ch (
         .clk        (clk),
         .reset_n    (reset_n),
         .advance    (advance),
         .next_count (next_count),
         .cmp_val    (cmp_val[i*CNT_W +: CNT_W]),
         .cmp_pulse  (cmp_pulse[i])
      );
   end
endmodule

// File: tb/tb_frame_timing_gen.sv
// tb_frame_timing_gen: randomized and directed checks of frame_timing_gen against a behavioural model
module tb_frame_timing_gen;
   localparam int CNT_W = 19;
   localparam int DP = 600;
   localparam int NUM_CH = 2;
   localparam int FN_W = 16;
   logic                    clk = 1'b0;
   logic                    reset_n = 1'b0;
   logic                    en = 1'b0;
   logic                    tick_en = 1'b0;
   logic                    period_wr = 1'b0;
   logic [CNT_W:0]          period_in = '0;
   logic                    frame_ack = 1'b0;
   logic [NUM_CH*CNT_W-1:0] cmp_val = '1;
   logic                    clr_overrun = 1'b0;
   logic                    frame_req;
   logic [NUM_CH-1:0]       cmp_pulse;
   logic [CNT_W-1:0]        count;
   logic [FN_W-1:0]         frame_num;
   logic                    overrun;
   logic [7:0]              overrun_cnt;
   int npass = 0;
   int ntot = 0;
   int m_cnt, m_per, m_pend, m_ocnt;
   bit m_pv, m_req, m_ovr;
   logic [FN_W-1:0] m_fn;
   logic [NUM_CH-1:0] m_pulse;

   frame_timing_gen #(.CNT_W(CNT_W), .DEFAULT_PERIOD(DP), .NUM_CH(NUM_CH), .FN_W(FN_W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .en          (en),
      .tick_en     (tick_en),
      .period_wr   (period_wr),
      .period_in   (period_in),
      .frame_ack   (frame_ack),
      .cmp_val     (cmp_val),
      .clr_overrun (clr_overrun),
      .frame_req   (frame_req),
      .cmp_pulse   (cmp_pulse),
      .count       (count),
      .frame_num   (frame_num),
      .overrun     (overrun),
      .overrun_cnt (overrun_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input longint act, input longint exp);
      ntot++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   task automatic model_reset();
      m_cnt = 0; m_per = DP; m_pend = 0; m_pv = 0; m_req = 1;
      m_fn = '0; m_ovr = 0; m_ocnt = 0; m_pulse = '0;
   endtask

   // Frame rules: a frame lasts m_per advances; pending period is taken up at the boundary.
   task automatic model_step();
      bit adv, bnd, evt;
      int nc;
      adv = en && tick_en;
      bnd = adv && (m_cnt == m_per - 1);
      evt = bnd && m_req && !frame_ack;
      nc = !adv ? m_cnt : (bnd ? 0 : m_cnt + 1);
      for (int i = 0; i < NUM_CH; i++)
         m_pulse[i] = adv && (nc == int'(cmp_val[i*CNT_W +: CNT_W]));
      if (bnd && m_pv) begin m_per = m_pend; m_pv = 0; end
      if (en && period_wr) begin m_pend = (period_in < 2) ? 2 : int'(period_in); m_pv = 1; end
      m_req = bnd ? 1'b1 : (frame_ack ? 1'b0 : m_req);
      if (evt) begin
         m_ovr = 1;
         m_ocnt = clr_overrun ? 1 : (m_ocnt < 255 ? m_ocnt + 1 : 255);
      end else if (clr_overrun) begin
         m_ovr = 0; m_ocnt = 0;
      end
      if (bnd) m_fn = m_fn + 1'b1;
      m_cnt = nc;
   endtask

   task automatic compare();
      check("count", count, m_cnt);
      check("frame_req", frame_req, m_req);
      check("frame_num", frame_num, m_fn);
      check("overrun", overrun, m_ovr);
      check("overrun_cnt", overrun_cnt, m_ocnt);
      check("cmp_pulse", cmp_pulse, m_pulse);
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      compare();
      period_wr = 0; frame_ack = 0; clr_overrun = 0;
   endtask

   task automatic run_until_boundary(input int max, output int n);
      logic [FN_W-1:0] fn0;
      fn0 = frame_num;
      n = 0;
      do begin cycle(); n++; end while (frame_num == fn0 && n < max);
      if (frame_num == fn0) check("boundary_timeout", n, -1);
   endtask

   task automatic do_reset();
      reset_n = 0;
      @(posedge clk);
      #1;
      reset_n = 1;
      model_reset();
      period_wr = 0; frame_ack = 0; clr_overrun = 0;
   endtask

   initial begin
      int n, p0, p1;
      logic [FN_W-1:0] fn0;
      repeat (2) @(posedge clk);
      do_reset();
      check("rst_count", count, 0);
      check("rst_req", frame_req, 1);
      check("rst_fn", frame_num, 0);
      check("rst_ovr", overrun, 0);
      check("rst_ocnt", overrun_cnt, 0);
      check("rst_pulse", cmp_pulse, 0);
      en = 1; tick_en = 1;
      frame_ack = 1; cycle();
      check("ack_clears_req", frame_req, 0);
      repeat (DP - 2) cycle();
      check("last_count", count, DP - 1);
      check("req_before_wrap", frame_req, 0);
      cycle();
      check("wrap_count", count, 0);
      check("wrap_req", frame_req, 1);
      check("wrap_fn", frame_num, 1);
      frame_ack = 1; cycle();
      repeat (4) cycle();
      period_wr = 1; period_in = 10; cycle();
      run_until_boundary(DP + 5, n); check("old_frame_len", n, DP - 6);
      run_until_boundary(30, n); check("p10_len_a", n, 10);
      run_until_boundary(30, n); check("p10_len_b", n, 10);
      period_wr = 1; period_in = 0; cycle();
      run_until_boundary(30, n); check("pre_clamp_len", n, 9);
      run_until_boundary(30, n); check("clamp_len_a", n, 2);
      run_until_boundary(30, n); check("clamp_len_b", n, 2);
      period_wr = 1; period_in = 10; cycle();
      run_until_boundary(30, n); check("p2_tail", n, 1);
      run_until_boundary(30, n); check("p10_again", n, 10);
      clr_overrun = 1; cycle();
      check("clr_ovr", overrun, 0);
      check("clr_ocnt", overrun_cnt, 0);
      for (int k = 0; k < 3; k++) run_until_boundary(30, n);
      check("ovr_set", overrun, 1);
      check("ovr_cnt3", overrun_cnt, 3);
      clr_overrun = 1; cycle();
      check("clr2_ovr", overrun, 0);
      check("clr2_ocnt", overrun_cnt, 0);
      for (int k = 0; k < 300; k++) run_until_boundary(30, n);
      check("ocnt_sat", overrun_cnt, 255);
      en = 0; frame_ack = 1; clr_overrun = 1; cycle();
      check("ack_en_low", frame_req, 0);
      check("hold_en_low", count, 0);
      en = 1;
      cmp_val = {19'd12, 19'd3};
      p0 = 0; p1 = 0; fn0 = frame_num;
      for (int k = 0; k < 200; k++) begin
         tick_en = (k % 4 == 3);
         cycle();
         p0 += int'(cmp_pulse[0]);
         p1 += int'(cmp_pulse[1]);
      end
      check("cmp0_pulses", p0, 5);
      check("cmp1_pulses", p1, 0);
      check("cmp_frames", frame_num - fn0, 5);
      for (int k = 0; k < 3000; k++) begin
         en = ($urandom_range(0, 9) != 0);
         tick_en = ($urandom_range(0, 3) != 0);
         period_wr = ($urandom_range(0, 39) == 0);
         period_in = ($urandom_range(0, 20));
         frame_ack = ($urandom_range(0, 5) == 0);
         clr_overrun = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 19) == 0)
            cmp_val = {19'($urandom_range(0, 25)), 19'($urandom_range(0, 25))};
         cycle();
      end
      en = 1; tick_en = 1;
      period_wr = 1; period_in = 5; cycle();
      do_reset();
      check("mid_rst_count", count, 0);
      check("mid_rst_req", frame_req, 1);
      check("mid_rst_fn", frame_num, 0);
      run_until_boundary(DP + 5, n); check("rst_period_a", n, DP);
      run_until_boundary(DP + 5, n); check("rst_period_b", n, DP);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
